// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
//   SZ_*            req_size encodings (byte / half / word / reserved)
//   state_e         controller state machine states
//   bytes_per_word  number of byte lanes in a DATA_W-bit word
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        StClear  = 2'd0,
        StIdle   = 2'd1,
        StRdWait = 2'd2
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory controller (big-endian).
// Byte offset i within a word lives in bits [(NB-1-i)*8 +: 8] of the word.
// Ports:
//   size      in   access size (dmem_pkg SZ_* encoding)
//   byte_off  in   byte offset of the access within the word
//   is_signed in   sign-extend sub-word loads
//   wdata     in   right-justified store data
//   rword     in   full storage word containing the access
//   be        out  byte enables, bit i = byte offset i
//   wlanes    out  store data steered onto its byte lanes
//   rdata     out  right-justified, extended load data
// Low offset bits are forced to the access alignment (half: bit 0, word: all).
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB    = bytes_per_word(DATA_W),
    localparam int unsigned LB    = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic [LB-1:0]     byte_off,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wlanes,
    output logic [DATA_W-1:0] rdata
);

    logic [LB-1:0] eff_off;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    int            sh;

    always_comb begin
        eff_off = byte_off;
        byte_v  = '0;
        half_v  = '0;
        sh      = 0;
        be      = '0;
        wlanes  = '0;
        rdata   = '0;
        case (size)
            SZ_BYTE: begin
                sh     = (int'(NB) - 1 - int'(byte_off)) * 8;
                be     = NB'(1) << byte_off;
                wlanes = DATA_W'(wdata[7:0]) << sh;
                byte_v = 8'(rword >> sh);
                rdata  = is_signed ? {{(DATA_W-8){byte_v[7]}}, byte_v} : DATA_W'(byte_v);
            end
            SZ_HALF: begin
                eff_off = {byte_off[LB-1:1], 1'b0};
                sh      = (int'(NB) - 2 - int'(eff_off)) * 8;
                be      = NB'(3) << eff_off;
                wlanes  = DATA_W'(wdata[15:0]) << sh;
                half_v  = 16'(rword >> sh);
                rdata   = is_signed ? {{(DATA_W-16){half_v[15]}}, half_v} : DATA_W'(half_v);
            end
            SZ_WORD: begin
                be     = '1;
                wlanes = wdata;
                rdata  = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed, big-endian data memory with a single-outstanding-load controller.
// After reset the storage is zero-filled one word per cycle before requests are taken.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_size,        store/load, size (dmem_pkg SZ_*), sign-extend,
//   req_signed, req_addr,    byte address, right-justified store data
//   req_wdata
//   rsp_valid, rsp_rdata,    one-cycle response strobe, load data (held between
//   rsp_err                  responses, 0 for stores), error flag
//   busy                     clear sweep or load in flight
// Build option: define DMEM_ALIGN_CHK_EN to reject misaligned accesses with rsp_err;
// otherwise misaligned addresses are silently aligned down.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned NB   = bytes_per_word(DATA_W);
    localparam int unsigned LB   = $clog2(NB);
    localparam int unsigned AW   = $clog2(DEPTH_BYTES);
    localparam int unsigned WIW  = AW - LB;
    localparam int unsigned NW   = DEPTH_BYTES / NB;
    localparam int unsigned LAST = RD_LAT - 1;

    logic [7:0]        mem_q [DEPTH_BYTES];

    state_e            state_q, state_d;
    logic [WIW-1:0]    clr_ptr_q, clr_ptr_d;

    // Read pipeline; the last stage doubles as the response register, so it also
    // takes store responses and holds rsp_rdata between responses.
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0] pipe_err_q, pipe_err_d;
    logic [DATA_W-1:0] pipe_data_q [RD_LAT];
    logic [DATA_W-1:0] pipe_data_d [RD_LAT];

    logic              accept, load_acc, store_acc;
    logic              in_range, acc_err;
    logic [32:0]       addr_ext;
    logic [WIW-1:0]    word_idx;
    logic [LB-1:0]     byte_off;
    logic [DATA_W-1:0] rword, lane_rdata, wlanes, ld_data;
    logic [NB-1:0]     be;

    // Address decode; 33-bit compare so BASE_ADDR + DEPTH_BYTES cannot wrap.
    assign addr_ext = {1'b0, req_addr};
    assign in_range = (addr_ext >= 33'(BASE_ADDR)) &&
                      (addr_ext < (33'(BASE_ADDR) + 33'(DEPTH_BYTES)));
    // BASE_ADDR is DEPTH_BYTES-aligned, so the low address bits index storage directly.
    assign word_idx = req_addr[AW-1:LB];
    assign byte_off = req_addr[LB-1:0];

`ifdef DMEM_ALIGN_CHK_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[LB-1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign acc_err = !in_range || (req_size == SZ_RSVD) || misaligned;
`else
    assign acc_err = !in_range || (req_size == SZ_RSVD);
`endif

    assign req_ready = (state_q == StIdle) && !rst;
    assign busy      = (state_q != StIdle) || rst;
    assign accept    = req_valid && req_ready;
    assign load_acc  = accept && !req_we;
    assign store_acc = accept && req_we;

    // Assemble the addressed word big-endian: lowest address in the top byte.
    always_comb begin
        rword = '0;
        for (int i = 0; i < int'(NB); i++) begin
            rword[(int'(NB) - 1 - i) * 8 +: 8] = mem_q[{word_idx, LB'(i)}];
        end
    end

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .size      (req_size),
        .byte_off  (byte_off),
        .is_signed (req_signed),
        .wdata     (req_wdata),
        .rword     (rword),
        .be        (be),
        .wlanes    (wlanes),
        .rdata     (lane_rdata)
    );

    assign ld_data = acc_err ? '0 : lane_rdata;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            StClear: begin
                clr_ptr_d = clr_ptr_q + WIW'(1);
                if (clr_ptr_q == WIW'(NW - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (load_acc) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (pipe_vld_q[LAST]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_err_d     = pipe_err_q;
        pipe_data_d    = pipe_data_q;
        pipe_vld_d[0]  = load_acc;
        if (load_acc) begin
            pipe_err_d[0]  = acc_err;
            pipe_data_d[0] = ld_data;
        end
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            if (pipe_vld_q[i-1]) begin
                pipe_err_d[i]  = pipe_err_q[i-1];
                pipe_data_d[i] = pipe_data_q[i-1];
            end
        end
        // Stores are only taken with no load in flight, so this never collides.
        if (store_acc) begin
            pipe_vld_d[LAST]  = 1'b1;
            pipe_err_d[LAST]  = acc_err;
            pipe_data_d[LAST] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StClear;
            clr_ptr_q         <= '0;
            pipe_vld_q        <= '0;
            pipe_err_q        <= '0;
            pipe_data_q[LAST] <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_err_q  <= pipe_err_d;
            pipe_data_q <= pipe_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                for (int i = 0; i < int'(NB); i++) begin
                    mem_q[{clr_ptr_q, LB'(i)}] <= 8'h00;
                end
            end else if (store_acc && !acc_err) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (be[i]) begin
                        mem_q[{word_idx, LB'(i)}] <= wlanes[(int'(NB) - 1 - i) * 8 +: 8];
                    end
                end
            end
        end
    end

    assign rsp_valid = pipe_vld_q[LAST] && !rst;
    assign rsp_err   = pipe_err_q[LAST] && !rst;
    assign rsp_rdata = rst ? '0 : pipe_data_q[LAST];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (DATA_W=32, 1 KiB at 0x400, RD_LAT=3).
// A byte-array reference model tracks storage contents; expected responses are
// derived from address range, size, alignment and big-endian byte order.
module tb_data_mem_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned BASE   = 32'h400;
    localparam int unsigned RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  model [DEPTH];
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DATA_W      (DATA_W),
        .DEPTH_BYTES (DEPTH),
        .BASE_ADDR   (BASE),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
        last_exp = '0;
    endtask

    // Called right after rst drops at a negedge: count cycles until req_ready.
    task automatic sweep(output int cycles, output int rsp_seen);
        cycles   = 0;
        rsp_seen = 0;
        #1;
        while (req_ready !== 1'b1 && cycles < 2000) begin
            if (rsp_valid === 1'b1) rsp_seen++;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n, input string tag);
        int cyc;
        int seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_busy"}, busy, 1);
        rst = 1'b0;
        sweep(cyc, seen);
        check({tag, "_sweep_cycles"}, cyc, 256);
        check({tag, "_sweep_no_rsp"}, seen, 0);
        model_clear();
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] a;
        logic [15:0] h;
        int          idx;
        int          guard;
        int          lat;
        exp_err  = (addr < BASE) || (addr >= BASE + DEPTH) || (size == 2'b11);
        exp_data = '0;
`ifdef DMEM_ALIGN_CHK_EN
        exp_err = exp_err || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        a       = addr;
`else
        a = (size == 2'b01) ? {addr[31:1], 1'b0} :
            (size == 2'b10) ? {addr[31:2], 2'b00} : addr;
`endif
        if (!exp_err) begin
            idx = int'(a - BASE);
            if (we) begin
                case (size)
                    2'b00: model[idx] = wdata[7:0];
                    2'b01: begin
                        model[idx]   = wdata[15:8];
                        model[idx+1] = wdata[7:0];
                    end
                    default: begin
                        model[idx]   = wdata[31:24];
                        model[idx+1] = wdata[23:16];
                        model[idx+2] = wdata[15:8];
                        model[idx+3] = wdata[7:0];
                    end
                endcase
            end else begin
                case (size)
                    2'b00: exp_data = sgn ? {{24{model[idx][7]}}, model[idx]} : {24'h0, model[idx]};
                    2'b01: begin
                        h        = {model[idx], model[idx+1]};
                        exp_data = sgn ? {{16{h[15]}}, h} : {16'h0, h};
                    end
                    default: exp_data = {model[idx], model[idx+1], model[idx+2], model[idx+3]};
                endcase
            end
        end

        guard = 0;
        while (req_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            check({tag, "_ready_timeout"}, req_ready, 1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 16) begin
            if (!we) check({tag, "_ready_busy_wait"}, {req_ready, busy}, 2'b01);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, we ? 1 : RD_LAT);
        check({tag, "_ready_at_rsp"}, req_ready, we);
        check({tag, "_rdata"}, rsp_rdata, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
        last_exp = exp_data;
    endtask

    task automatic quiet(input string tag);
        @(negedge clk);
        check({tag, "_valid_low"}, rsp_valid, 0);
        check({tag, "_rdata_held"}, rsp_rdata, last_exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        int          r2;
        int          cyc;
        int          seen;
        logic        rw;
        logic [1:0]  rsz;
        logic [31:0] raddr;

        do_reset(3, "rst");
        xact(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, "ld_400_clear");
        quiet("ld_400");

        // Big-endian sub-word extraction with both extension modes; the first
        // load also lands the cycle right after the store.
        xact(1'b1, 2'b10, 1'b0, 32'h404, 32'hDEADBEEF, "st_404");
        xact(1'b0, 2'b00, 1'b1, 32'h405, 32'h0, "ld_b405_s");
        xact(1'b0, 2'b00, 1'b0, 32'h405, 32'h0, "ld_b405_u");
        xact(1'b0, 2'b01, 1'b1, 32'h404, 32'h0, "ld_h404_s");
        xact(1'b0, 2'b10, 1'b1, 32'h404, 32'h0, "ld_w404");
        quiet("ld_w404");

        // Range boundaries.
        xact(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, "ld_3fc_oor");
        xact(1'b1, 2'b10, 1'b0, 32'h800, 32'hCAFEF00D, "st_800_oor");
        xact(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, "ld_400_unchanged");
        xact(1'b1, 2'b10, 1'b0, 32'h7FC, 32'h01234567, "st_7fc_top");
        xact(1'b0, 2'b00, 1'b0, 32'h7FF, 32'h0, "ld_b7ff_top");

        // Misaligned half store, then inspect the neighbouring bytes.
        xact(1'b1, 2'b01, 1'b0, 32'h407, 32'h00001234, "st_h407_mis");
        xact(1'b0, 2'b00, 1'b0, 32'h406, 32'h0, "ld_b406");
        xact(1'b0, 2'b00, 1'b0, 32'h407, 32'h0, "ld_b407");
        xact(1'b0, 2'b10, 1'b0, 32'h405, 32'h0, "ld_w405_mis");

        // Reserved size.
        xact(1'b1, 2'b11, 1'b0, 32'h408, 32'hFFFFFFFF, "st_rsvd");
        xact(1'b0, 2'b11, 1'b0, 32'h404, 32'h0, "ld_rsvd");
        xact(1'b0, 2'b10, 1'b0, 32'h408, 32'h0, "ld_408_after_rsvd");
        quiet("ld_408");

        for (int k = 0; k < 200; k++) begin
            rw  = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 15));
            rsz = (r == 15) ? 2'b11 : 2'(r % 3);
            r2  = int'($urandom_range(0, 19));
            if (r2 == 0)      raddr = 32'h3F0 + $urandom_range(0, 15);
            else if (r2 == 1) raddr = 32'h800 + $urandom_range(0, 15);
            else if (r2 == 2) raddr = 32'h7F0 + $urandom_range(0, 15);
            else              raddr = 32'h400 + $urandom_range(0, 63);
            xact(rw, rsz, 1'($urandom_range(0, 1)), raddr, $urandom, "rand");
        end

        // Reset the cycle after a load is accepted: the load must vanish.
        xact(1'b1, 2'b10, 1'b0, 32'h404, 32'h89ABCDEF, "st_404_pre_rst");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h404;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("rst_rd_valid_low", rsp_valid, 0);
        check("rst_rd_ready_low", req_ready, 0);
        rst = 1'b0;
        sweep(cyc, seen);
        check("rst_rd_sweep_cycles", cyc, 256);
        check("rst_rd_no_rsp", seen, 0);
        model_clear();
        xact(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, "ld_404_after_rst");

        // Reset during the sweep restarts it from the first word.
        xact(1'b1, 2'b10, 1'b0, 32'h7FC, 32'h55AA55AA, "st_7fc_pre_clr");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_clear_ready_low", req_ready, 0);
        check("mid_clear_busy", busy, 1);
        do_reset(1, "rst_mid_clear");
        xact(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, "ld_7fc_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; legal values 32 and 64.
REQ-002 Parameter DEPTH_BYTES, default 1024: storage size in bytes; a power of two and a multiple of DATA_W/8.
REQ-003 Parameter BASE_ADDR, default 1024: byte address of storage byte 0; must be aligned to DEPTH_BYTES.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles; legal range 1..4.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller accepts a request this cycle.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is reserved.
REQ-011 req_signed  in  1  sign-extend a sub-word load.
REQ-012 req_addr  in  32  byte address.
REQ-013 req_wdata  in  DATA_W  store data, right-justified.
REQ-014 rsp_valid  out  1  one-cycle response strobe.
REQ-015 rsp_rdata  out  DATA_W  load data, right-justified.
REQ-016 rsp_err  out  1  error flag, qualified by rsp_valid.
REQ-017 busy  out  1  clear sweep or read in flight.

Function
REQ-018 A request is accepted on any cycle where req_valid and req_ready are both 1.
REQ-019 Byte order is big-endian: the lowest address holds the most significant byte of a word.
REQ-020 The state machine has three states:
- CLEAR: zero-fills storage; req_ready = 0.
- IDLE: req_ready = 1.
- RD_WAIT: req_ready = 0.
REQ-021 State transitions:
- CLEAR to IDLE after the sweep completes.
- IDLE to RD_WAIT on an accepted load.
- RD_WAIT to IDLE on the cycle rsp_valid is asserted.
REQ-022 A store is accepted in IDLE and updates only the addressed bytes at that edge; rsp_valid asserts on the next cycle; the state stays IDLE, so back-to-back stores are allowed.
REQ-023 A load asserts rsp_valid exactly RD_LAT cycles after acceptance; only one load is outstanding at a time.
REQ-024 Read-after-write: a load accepted the cycle after a store to the same bytes returns the new data.
REQ-025 A sub-word load is zero-extended when req_signed = 0 and sign-extended when req_signed = 1; a full-word load ignores req_signed.
REQ-026 Out-of-range accesses (req_addr < BASE_ADDR or req_addr >= BASE_ADDR + DEPTH_BYTES):
- A store is dropped.
- A load returns 0.
- rsp_err = 1.
REQ-027 req_size = 11: treated as out-of-range (dropped, load returns 0, rsp_err = 1).
REQ-028 A request that is both in range and legal gives rsp_err = 0.
REQ-029 rsp_rdata holds its last value while rsp_valid = 0; it returns 0 for store responses.

Reset
REQ-030 While rst = 1:
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0, busy = 1.
- State is CLEAR and the clear pointer is 0.
REQ-031 After rst deasserts, CLEAR writes one zero word per cycle for DEPTH_BYTES/(DATA_W/8) cycles (256 at defaults), then enters IDLE.
REQ-032 rst during RD_WAIT discards the in-flight load; no rsp_valid is issued for it.
REQ-033 rst during CLEAR restarts the sweep from pointer 0.

Configuration
REQ-034 Macro DMEM_ALIGN_CHK_EN defined: a misaligned access gives rsp_err = 1, leaves storage unchanged, and loads return 0.
- Misaligned means a half at an odd address, or a word not DATA_W/8-aligned.
REQ-035 Macro DMEM_ALIGN_CHK_EN undefined: low address bits are forced to the access alignment, and misalignment never sets rsp_err.

Structure
REQ-036 Package dmem_pkg holds the req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the function computing DATA_W/8.
REQ-037 Sub-module dmem_lane_align holds the combinational logic:
- byte-enable and write-data lane steering;
- load lane extraction;
- sign/zero extension.
REQ-038 Storage is a byte array inside data_mem_ctrl; the read pipeline is a RD_LAT-deep shift register of data and err.

Verification
REQ-039 Reset sweep: pulse rst for 3 cycles -> req_ready = 0 for 256 cycles after release, then 1; a word load at 0x400 returns 0x00000000.
REQ-040 Store word 0xDEADBEEF at 0x404, then load byte at 0x405:
- req_signed = 1 -> 0xFFFFFFAD.
- req_signed = 0 -> 0x000000AD.
REQ-041 Latency: RD_LAT = 3, load accepted in cycle 10 -> rsp_valid only in cycle 13; req_ready = 0 in cycles 11-13.
REQ-042 Range: load at 0x3FC, then store at 0x800 -> both give rsp_err = 1; the load returns 0; storage is unchanged.
REQ-043 Alignment: half store 0x1234 at 0x407:
- With DMEM_ALIGN_CHK_EN: rsp_err = 1, no write.
- Without: bytes 0x406/0x407 become 0x12/0x34.
REQ-044 Reset mid-read: rst asserted the cycle after a load is accepted -> no rsp_valid is issued, and the CLEAR sweep restarts.
